// File: rtl/systolic_array_pkg.sv
// Shared types and defaults for the systolic-array scratchpad.
//  - word_t     : one FP32 bit pattern as stored in the scratchpad
//  - sp_state_e : scratchpad batch controller states
//  - bank_of()  : bank index of a word address (low address bits)
package systolic_array_pkg;

    localparam int SA_N      = 4;
    localparam int SP_DEPTH  = 8192;
    localparam int SP_NBANKS = 4;
    localparam int SP_RD_LAT = 1;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } sp_state_e;

    // Banks are interleaved on the low address bits; nbanks is a power of two.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned nbanks);
        return addr & (nbanks - 32'd1);
    endfunction

endpackage

// File: rtl/sa_sp_bank.sv
// One scratchpad bank: ROWS x word_t single-port array with an RD_LAT-deep
// registered read pipeline.
//  clk_i    clock
//  rd_en_i  read the row at addr_i; data appears on rdata_o RD_LAT cycles later
//  wr_en_i  write wdata_i to the row at addr_i (ignored when rd_en_i is high)
//  addr_i   row address
//  wdata_i  write data
//  rdata_o  read data, last pipeline stage
// Contents are never reset.
module sa_sp_bank
    import systolic_array_pkg::*;
#(
    parameter int ROWS   = 2048,
    parameter int RW     = 11,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rd_en_i,
    input  logic          wr_en_i,
    input  logic [RW-1:0] addr_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q  [ROWS];
    word_t pipe_q [RD_LAT];

    // Array access (read has priority) and the read-data pipeline.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            pipe_q[0] <= mem_q[addr_i];
        end else if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/sa_banked_scratchpad.sv
// Banked scratchpad feeding the systolic array. A batch of N X-lane and N
// W-lane word addresses is accepted in IDLE, served over as many bank passes
// as the worst bank conflict needs, and all 2N words are returned together on
// a one-cycle rsp_valid pulse. A single-word write port loads tiles in IDLE.
//  clk, n_rst          clock, synchronous active-low reset
//  wr_en/addr/data     write request; wr_ready high while IDLE
//  req_valid/req_ready batch handshake (a write in the same cycle wins)
//  sc_x_queue/_w_queue N packed 32-bit lane addresses, lane i at [32i +: 32]
//  sc_valid_queue      per-lane enable, lane i gates both X and W lane i
//  sc_x_data/_w_data   registered response words, held until the next response
//  rsp_valid           one-cycle response pulse
//  addr_err            sticky out-of-range flag (enabled lane or write)
module sa_banked_scratchpad
    import systolic_array_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int DEPTH  = SP_DEPTH,
    parameter int NBANKS = SP_NBANKS,
    parameter int RD_LAT = SP_RD_LAT
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            wr_en,
    input  logic [31:0]     wr_addr,
    input  logic [31:0]     wr_data,
    output logic            wr_ready,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [N*32-1:0] sc_x_queue,
    input  logic [N*32-1:0] sc_w_queue,
    input  logic [N-1:0]    sc_valid_queue,
    output logic [N*32-1:0] sc_x_data,
    output logic [N*32-1:0] sc_w_data,
    output logic            rsp_valid,
    output logic            addr_err
);

    localparam int L    = 2 * N;          // X lanes 0..N-1, W lanes N..2N-1
    localparam int LW   = $clog2(L);
    localparam int BW   = $clog2(NBANKS);
    localparam int AW   = $clog2(DEPTH);
    localparam int RW   = AW - BW;
    localparam int ROWS = DEPTH / NBANKS;
    localparam int CW   = 8;

    sp_state_e         state_q, state_d;
    logic [L-1:0]      pending_q, pending_d;
    logic [L-1:0]      req_mask_s, grant_s;
    logic [AW-1:0]     addr_q    [L];
    word_t             in_addr_s [L];
    logic              req_err_s, accept_s, wr_fire_s, wr_range_err_s;
    logic              addr_err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NBANKS-1:0] sel_vld_s;
    logic [LW-1:0]     sel_lane_s  [NBANKS];
    logic [RW-1:0]     sel_row_s   [NBANKS];
    logic [NBANKS-1:0] bank_rd_s, bank_wr_s;
    logic [RW-1:0]     bank_addr_s [NBANKS];
    word_t             bank_rdata_s[NBANKS];

    logic [NBANKS-1:0] tag_vld_q  [RD_LAT];
    logic [LW-1:0]     tag_lane_q [RD_LAT][NBANKS];

    word_t             stage_q [L];
    word_t             stage_d [L];
    logic [N*32-1:0]   x_data_q, w_data_q;
    logic              rsp_valid_q, addr_err_q;

    assign wr_ready  = (state_q == IDLE);
    assign req_ready = (state_q == IDLE) && !wr_en;

    assign wr_fire_s      = n_rst && wr_en && (state_q == IDLE) && (wr_addr <  32'(DEPTH));
    assign wr_range_err_s =          wr_en && (state_q == IDLE) && (wr_addr >= 32'(DEPTH));

    // Unpack lane addresses and classify lanes as real bank requests or errors.
    always_comb begin
        req_err_s  = 1'b0;
        req_mask_s = '0;
        for (int i = 0; i < N; i++) begin
            in_addr_s[i]     = sc_x_queue[i*32 +: 32];
            in_addr_s[i + N] = sc_w_queue[i*32 +: 32];
            req_mask_s[i]     = sc_valid_queue[i] && (in_addr_s[i]     < 32'(DEPTH));
            req_mask_s[i + N] = sc_valid_queue[i] && (in_addr_s[i + N] < 32'(DEPTH));
            req_err_s = req_err_s
                      | (sc_valid_queue[i] && (in_addr_s[i]     >= 32'(DEPTH)))
                      | (sc_valid_queue[i] && (in_addr_s[i + N] >= 32'(DEPTH)));
        end
    end

    // Per-bank fixed-priority pick among pending lanes; scanning downwards lets
    // the lowest lane index (X0 first, W last) overwrite any higher candidate.
    always_comb begin
        logic hit;
        hit       = 1'b0;
        grant_s   = '0;
        sel_vld_s = '0;
        for (int b = 0; b < NBANKS; b++) begin
            sel_lane_s[b] = '0;
            sel_row_s[b]  = '0;
            for (int j = L - 1; j >= 0; j--) begin
                hit = (state_q == ISSUE) && pending_q[j]
                   && (bank_of(32'(addr_q[j]), NBANKS) == 32'(b));
                sel_vld_s[b]  = sel_vld_s[b] | hit;
                sel_lane_s[b] = hit ? LW'(j) : sel_lane_s[b];
                sel_row_s[b]  = hit ? addr_q[j][AW-1:BW] : sel_row_s[b];
            end
            grant_s = grant_s | (L'(sel_vld_s[b]) << sel_lane_s[b]);
        end
    end

    // Bank port muxing: reads only happen in ISSUE, writes only in IDLE.
    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            bank_rd_s[b]   = sel_vld_s[b];
            bank_wr_s[b]   = wr_fire_s && (bank_of(wr_addr, NBANKS) == 32'(b));
            bank_addr_s[b] = sel_vld_s[b] ? sel_row_s[b] : wr_addr[AW-1:BW];
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        sa_sp_bank #(
            .ROWS   (ROWS),
            .RW     (RW),
            .RD_LAT (RD_LAT)
        ) u_bank (
            .clk_i   (clk),
            .rd_en_i (bank_rd_s[b]),
            .wr_en_i (bank_wr_s[b]),
            .addr_i  (bank_addr_s[b]),
            .wdata_i (wr_data),
            .rdata_o (bank_rdata_s[b])
        );
    end

    // Batch controller next state, pending mask and drain counter.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        accept_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !wr_en) begin
                    accept_s  = 1'b1;
                    pending_d = req_mask_s;
                    state_d   = ISSUE;
                end else begin
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                pending_d = pending_q & ~grant_s;
                if (pending_d == '0) begin
                    cnt_d   = '0;
                    state_d = (RD_LAT == 1) ? RESP : DRAIN;
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                // Covers the extra RD_LAT-1 cycles of the last pass's reads.
                if (cnt_q == CW'(RD_LAT - 2)) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        addr_err_d = addr_err_q | (accept_s & req_err_s) | wr_range_err_s;
    end

    // Response staging: cleared on accept so unserved lanes read as zero, then
    // each returning bank word is steered to the lane recorded in its tag.
    always_comb begin
        for (int j = 0; j < L; j++) begin
            stage_d[j] = accept_s ? 32'h0 : stage_q[j];
        end
        for (int b = 0; b < NBANKS; b++) begin
            for (int j = 0; j < L; j++) begin
                stage_d[j] = (tag_vld_q[RD_LAT-1][b] && (tag_lane_q[RD_LAT-1][b] == LW'(j)))
                           ? bank_rdata_s[b] : stage_d[j];
            end
        end
    end

    // Control state, staging, tag valids and registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            cnt_q       <= '0;
            addr_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            x_data_q    <= '0;
            w_data_q    <= '0;
            for (int j = 0; j < L; j++) begin
                stage_q[j] <= 32'h0;
                addr_q[j]  <= '0;
            end
            for (int s = 0; s < RD_LAT; s++) begin
                tag_vld_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            addr_err_q  <= addr_err_d;
            rsp_valid_q <= (state_q == RESP);
            for (int j = 0; j < L; j++) begin
                stage_q[j] <= stage_d[j];
                if (accept_s) begin
                    addr_q[j] <= in_addr_s[j][AW-1:0];
                end
            end
            tag_vld_q[0] <= sel_vld_s;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
            end
            if (state_q == RESP) begin
                for (int i = 0; i < N; i++) begin
                    x_data_q[i*32 +: 32] <= stage_d[i];
                    w_data_q[i*32 +: 32] <= stage_d[i + N];
                end
            end
        end
    end

    // Lane tags only matter alongside their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANKS; b++) begin
            tag_lane_q[0][b] <= sel_lane_s[b];
            for (int s = 1; s < RD_LAT; s++) begin
                tag_lane_q[s][b] <= tag_lane_q[s-1][b];
            end
        end
    end

    assign sc_x_data = x_data_q;
    assign sc_w_data = w_data_q;
    assign rsp_valid = rsp_valid_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_sa_banked_scratchpad.sv
// Bench for sa_banked_scratchpad: a word-array model of the scratchpad that
// predicts response timing from the worst bank conflict, checked every cycle,
// plus hand-computed literals for the directed scenarios.
module tb_sa_banked_scratchpad;

    localparam int N      = 4;
    localparam int DEPTH  = 8192;
    localparam int NB     = 4;
    localparam int RD_LAT = 1;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [31:0]  wr_addr = 32'h0;
    logic [31:0]  wr_data = 32'h0;
    logic         req_valid = 1'b0;
    logic [127:0] sc_x_queue = 128'h0;
    logic [127:0] sc_w_queue = 128'h0;
    logic [3:0]   sc_valid_queue = 4'h0;
    logic         wr_ready, req_ready, rsp_valid, addr_err;
    logic [127:0] sc_x_data, sc_w_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sa_banked_scratchpad dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .sc_x_queue     (sc_x_queue),
        .sc_w_queue     (sc_w_queue),
        .sc_valid_queue (sc_valid_queue),
        .sc_x_data      (sc_x_data),
        .sc_w_data      (sc_w_data),
        .rsp_valid      (rsp_valid),
        .addr_err       (addr_err)
    );

    // ---------------- behavioural model ----------------
    bit [31:0]    mem [DEPTH];
    int           cnt_m [NB];
    bit           busy = 1'b0;
    bit           err_m = 1'b0;
    bit           rsp_now = 1'b0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           rsp_cyc = 0;
    int           last_p = 0;
    int           last_lat = 0;
    logic [127:0] exp_x = 128'h0, exp_w = 128'h0;
    logic [127:0] hold_x = 128'h0, hold_w = 128'h0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic lane_read(input logic [31:0] a, input logic v, output logic [31:0] d);
        d = 32'h0;
        if (v) begin
            if (a >= 32'(DEPTH)) begin
                err_m = 1'b1;
            end else begin
                cnt_m[a % NB]++;
                d = mem[a];
            end
        end
    endtask

    task automatic model_accept();
        logic [31:0] d;
        int p;
        for (int b = 0; b < NB; b++) cnt_m[b] = 0;
        for (int i = 0; i < N; i++) begin
            lane_read(sc_x_queue[i*32 +: 32], sc_valid_queue[i], d);
            exp_x[i*32 +: 32] = d;
            lane_read(sc_w_queue[i*32 +: 32], sc_valid_queue[i], d);
            exp_w[i*32 +: 32] = d;
        end
        p = 0;
        for (int b = 0; b < NB; b++) if (cnt_m[b] > p) p = cnt_m[b];
        last_p   = p;
        acc_cyc  = cyc;
        rsp_cyc  = cyc + ((p > 0) ? p : 1) + RD_LAT;
        last_lat = rsp_cyc - acc_cyc;
        busy     = 1'b1;
    endtask

    // Model update at each edge, then compare every output just after it.
    always @(posedge clk) begin
        cyc++;
        rsp_now = 1'b0;
        if (!n_rst) begin
            busy   = 1'b0;
            err_m  = 1'b0;
            hold_x = 128'h0;
            hold_w = 128'h0;
        end else begin
            if (!busy && wr_en) begin
                if (wr_addr < 32'(DEPTH)) mem[wr_addr] = wr_data;
                else err_m = 1'b1;
            end else if (!busy && req_valid) begin
                model_accept();
            end else if (busy && cyc == rsp_cyc) begin
                rsp_now = 1'b1;
                hold_x  = exp_x;
                hold_w  = exp_w;
                busy    = 1'b0;
            end
        end
        #1;
        chk("rsp_valid", {127'h0, rsp_valid}, {127'h0, rsp_now});
        chk("sc_x_data", sc_x_data, hold_x);
        chk("sc_w_data", sc_w_data, hold_w);
        chk("addr_err",  {127'h0, addr_err},  {127'h0, err_m});
        chk("wr_ready",  {127'h0, wr_ready},  {127'h0, !busy});
        chk("req_ready", {127'h0, req_ready}, {127'h0, (!busy && !wr_en)});
    end

    // ---------------- stimulus ----------------
    task automatic set_batch(input logic [31:0] x0, x1, x2, x3, w0, w1, w2, w3,
                             input logic [3:0] v);
        sc_x_queue     = {x3, x2, x1, x0};
        sc_w_queue     = {w3, w2, w1, w0};
        sc_valid_queue = v;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (busy && k < 64) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL batch_timeout: response still pending after %0d cycles", k);
        end
    endtask

    task automatic run_batch(input logic [31:0] x0, x1, x2, x3, w0, w1, w2, w3,
                             input logic [3:0] v);
        @(negedge clk);
        set_batch(x0, x1, x2, x3, w0, w1, w2, w3, v);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Load words 0..31 with 1.0f + i (bit pattern).
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 32'(i);
            wr_data = 32'h3F800000 + 32'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;

        // 1: every bank hit twice.
        run_batch(0, 1, 2, 3, 4, 5, 6, 7, 4'hF);
        chk("t1_p",   128'(last_p),   128'd2);
        chk("t1_lat", 128'(last_lat), 128'd3);
        chk("t1_x0",  {96'h0, sc_x_data[31:0]},   {96'h0, 32'h3F800000});
        chk("t1_x3",  {96'h0, sc_x_data[127:96]}, {96'h0, 32'h3F800003});
        chk("t1_w3",  {96'h0, sc_w_data[127:96]}, {96'h0, 32'h3F800007});

        // 2: all eight requests in bank 0.
        run_batch(0, 4, 8, 12, 16, 20, 24, 28, 4'hF);
        chk("t2_p",   128'(last_p),   128'd8);
        chk("t2_lat", 128'(last_lat), 128'd9);
        chk("t2_x1",  {96'h0, sc_x_data[63:32]},  {96'h0, 32'h3F800004});
        chk("t2_w3",  {96'h0, sc_w_data[127:96]}, {96'h0, 32'h3F80001C});

        // No lane enabled: one empty pass, all-zero data.
        run_batch(0, 1, 2, 3, 4, 5, 6, 7, 4'h0);
        chk("p0_lat", 128'(last_lat), 128'd2);
        chk("p0_x",   sc_x_data, 128'h0);

        // 3: lanes 1 and 3 disabled.
        run_batch(0, 1, 2, 3, 4, 5, 6, 7, 4'b0101);
        chk("t3_p",   128'(last_p), 128'd2);
        chk("t3_x1",  {96'h0, sc_x_data[63:32]}, 128'h0);
        chk("t3_x2",  {96'h0, sc_x_data[95:64]}, {96'h0, 32'h3F800002});
        chk("t3_err", {127'h0, addr_err}, 128'h0);

        // 4: out-of-range X lane 2, then a clean batch keeps the sticky flag.
        run_batch(0, 1, DEPTH + 3, 3, 4, 5, 6, 7, 4'hF);
        chk("t4_x2",  {96'h0, sc_x_data[95:64]}, 128'h0);
        chk("t4_err", {127'h0, addr_err}, 128'h1);
        run_batch(8, 9, 10, 11, 12, 13, 14, 15, 4'hF);
        chk("t4_err_sticky", {127'h0, addr_err}, 128'h1);
        chk("t4_x0", {96'h0, sc_x_data[31:0]}, {96'h0, 32'h3F800008});

        // 5a: write and batch together; the write wins and the batch sees it.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 32'd5;
        wr_data = 32'hDEADBEEF;
        set_batch(5, 1, 2, 3, 4, 5, 6, 7, 4'hF);
        req_valid = 1'b1;
        #1 chk("t5_req_ready", {127'h0, req_ready}, 128'h0);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();
        chk("t5_p",  128'(last_p), 128'd3);
        chk("t5_x0", {96'h0, sc_x_data[31:0]},  {96'h0, 32'hDEADBEEF});
        chk("t5_w1", {96'h0, sc_w_data[63:32]}, {96'h0, 32'hDEADBEEF});

        // 5b: a write during ISSUE is dropped.
        @(negedge clk);
        set_batch(0, 4, 8, 12, 16, 20, 24, 28, 4'hF);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 32'd0;
        wr_data   = 32'h12345678;
        #1 chk("t5_wr_ready_busy", {127'h0, wr_ready}, 128'h0);
        @(negedge clk);
        wr_en = 1'b0;
        wait_done();
        run_batch(0, 1, 2, 3, 4, 5, 6, 7, 4'hF);
        chk("t5_mem_kept", {96'h0, sc_x_data[31:0]}, {96'h0, 32'h3F800000});

        // 6: reset in the middle of a P=8 batch; no pulse may follow.
        @(negedge clk);
        set_batch(0, 4, 8, 12, 16, 20, 24, 28, 4'hF);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (12) @(negedge clk);
        run_batch(1, 2, 3, 28, 9, 10, 11, 12, 4'hF);
        chk("t6_x3",  {96'h0, sc_x_data[127:96]}, {96'h0, 32'h3F80001C});
        chk("t6_w0",  {96'h0, sc_w_data[31:0]},   {96'h0, 32'h3F800009});
        chk("t6_err", {127'h0, addr_err}, 128'h0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
